// File: rtl/lsu_mem_port.sv
// Load/store memory-access engine: takes one op, runs the req/gnt/rvalid handshake,
// and returns lane-aligned store data or extended load data to writeback.
module lsu_mem_port #(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic            op_is_load,
  input  logic [2:0]      op_funct3,
  input  logic [XLEN-1:0] op_addr,
  input  logic [XLEN-1:0] op_wdata,
  input  logic [4:0]      op_rd,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            err_misalign,
  output logic            err_timeout
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_e          state_q, state_d;
  logic            is_load_q, is_load_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      alow_q, alow_d;
  logic [4:0]      rd_q, rd_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]      mem_be_q, mem_be_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic            wb_valid_q, wb_valid_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            err_mis_q, err_mis_d;
  logic            err_to_q, err_to_d;
  logic [7:0]      cnt_q, cnt_d;

  logic            legal, aligned;
  logic [3:0]      lane_be;
  logic [XLEN-1:0] lane_wdata;
  logic [XLEN-1:0] rshift, load_data;

  always_comb begin
    legal      = 1'b0;
    aligned    = 1'b1;
    lane_be    = 4'b1111;
    lane_wdata = op_wdata;
    case (op_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = op_is_load;
      default:                legal = 1'b0;
    endcase
    case (op_funct3[1:0])
      2'b00: begin
        lane_be    = 4'b0001 << op_addr[1:0];
        lane_wdata = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        aligned    = ~op_addr[0];
        lane_be    = op_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{op_wdata[15:0]}};
      end
      default: aligned = (op_addr[1:0] == 2'b00);
    endcase
  end

  // Load lane is selected by the byte offset captured at accept time.
  always_comb begin
    rshift = mem_rdata >> {alow_q, 3'b000};
    case (funct3_q)
      3'b000:  load_data = {{24{rshift[7]}}, rshift[7:0]};
      3'b001:  load_data = {{16{rshift[15]}}, rshift[15:0]};
      3'b100:  load_data = {24'b0, rshift[7:0]};
      3'b101:  load_data = {16'b0, rshift[15:0]};
      default: load_data = rshift;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    is_load_d   = is_load_q;
    funct3_d    = funct3_q;
    alow_d      = alow_q;
    rd_d        = rd_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    err_mis_d   = 1'b0;
    err_to_d    = 1'b0;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (op_valid) begin
          if (legal && aligned) begin
            is_load_d   = op_is_load;
            funct3_d    = op_funct3;
            alow_d      = op_addr[1:0];
            rd_d        = op_rd;
            mem_req_d   = 1'b1;
            mem_we_d    = ~op_is_load;
            mem_addr_d  = {op_addr[XLEN-1:2], 2'b00};
            mem_be_d    = lane_be;
            mem_wdata_d = lane_wdata;
            cnt_d       = 8'd0;
            state_d     = REQ;
          end else begin
            err_mis_d = 1'b1;
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          cnt_d     = 8'd0;
          state_d   = is_load_q ? WAIT : IDLE;
        end else if (cnt_q == TO_LAST) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          err_to_d  = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = load_data;
          state_d    = IDLE;
        end else if (cnt_q == TO_LAST) begin
          err_to_d = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      is_load_q   <= 1'b0;
      funct3_q    <= 3'b0;
      alow_q      <= 2'b0;
      rd_q        <= 5'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0;
      mem_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= 5'b0;
      wb_data_q   <= '0;
      err_mis_q   <= 1'b0;
      err_to_q    <= 1'b0;
      cnt_q       <= 8'd0;
    end else begin
      is_load_q   <= is_load_d;
      funct3_q    <= funct3_d;
      alow_q      <= alow_d;
      rd_q        <= rd_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      err_mis_q   <= err_mis_d;
      err_to_q    <= err_to_d;
      cnt_q       <= cnt_d;
    end
  end

  assign op_ready     = (state_q == IDLE);
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_be       = mem_be_q;
  assign mem_wdata    = mem_wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign err_misalign = err_mis_q;
  assign err_timeout  = err_to_q;

endmodule
